// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the R/I/J MIPS datapath.
// State is registered; every strobe and select is decoded combinationally from state, IR fields, zf and mem_ready.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zf,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic [2:0]       state,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       w_r_s,
    output logic [1:0]       w_r_data_s,
    output logic             rt_imm_s,
    output logic             imm_s,
    output logic [2:0]       alu_op,
    output logic             err,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd7
    } state_t;

    localparam int WD_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state_q;
    logic [WD_W-1:0]  wd_cnt;
    logic [CNT_W-1:0] instr_cnt_q;

    logic       legal;
    logic       is_r, is_jr, is_imm, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic [2:0] dec_alu;
    logic       dec_imm_s;
    logic       retire;
    logic       wd_expire;
    state_t     ret_next;

    always_comb begin
        legal     = 1'b0;
        is_r      = 1'b0;
        is_jr     = 1'b0;
        is_imm    = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        dec_alu   = 3'b000;
        dec_imm_s = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin legal = 1'b1; is_r = 1'b1; dec_alu = 3'b010; end
                    6'b100010: begin legal = 1'b1; is_r = 1'b1; dec_alu = 3'b110; end
                    6'b100100: begin legal = 1'b1; is_r = 1'b1; dec_alu = 3'b000; end
                    6'b100101: begin legal = 1'b1; is_r = 1'b1; dec_alu = 3'b001; end
                    6'b100110: begin legal = 1'b1; is_r = 1'b1; dec_alu = 3'b011; end
                    6'b100111: begin legal = 1'b1; is_r = 1'b1; dec_alu = 3'b100; end
                    6'b101010: begin legal = 1'b1; is_r = 1'b1; dec_alu = 3'b111; end
                    6'b000010: begin legal = 1'b1; is_r = 1'b1; dec_alu = 3'b101; end
                    6'b001000: begin legal = 1'b1; is_jr = 1'b1; end
                    default: ;
                endcase
            end
            6'b001000: begin legal = 1'b1; is_imm = 1'b1; dec_alu = 3'b010; dec_imm_s = 1'b1; end
            6'b001100: begin legal = 1'b1; is_imm = 1'b1; dec_alu = 3'b000; end
            6'b001110: begin legal = 1'b1; is_imm = 1'b1; dec_alu = 3'b011; end
            6'b001011: begin legal = 1'b1; is_imm = 1'b1; dec_alu = 3'b111; dec_imm_s = 1'b1; end
            6'b100011: begin legal = 1'b1; is_lw  = 1'b1; dec_alu = 3'b010; dec_imm_s = 1'b1; end
            6'b101011: begin legal = 1'b1; is_sw  = 1'b1; dec_alu = 3'b010; dec_imm_s = 1'b1; end
            6'b000100: begin legal = 1'b1; is_beq = 1'b1; dec_alu = 3'b110; end
            6'b000101: begin legal = 1'b1; is_bne = 1'b1; dec_alu = 3'b110; end
            6'b000010: begin legal = 1'b1; is_j   = 1'b1; end
            6'b000011: begin legal = 1'b1; is_jal = 1'b1; end
            default: ;
        endcase
    end

    // mem_ready is a completion strobe: the request (mem_read/mem_write) is held
    // from the first IF/MEM cycle until the cycle mem_ready=1, which completes it.
    assign wd_expire = (MEM_TIMEOUT != 0) && (wd_cnt == WD_LAST) && !mem_ready;
    assign ret_next  = halt_req ? S_HALT : S_IF;

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        w_r_s      = 2'b00;
        w_r_data_s = 2'b00;
        rt_imm_s   = 1'b0;
        imm_s      = 1'b0;
        alu_op     = 3'b000;
        retire     = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_ID: begin
                if (is_j || is_jal) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
                if (is_jal) begin
                    reg_write  = 1'b1;
                    w_r_s      = 2'b10;
                    w_r_data_s = 2'b10;
                end
                if (is_jr) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b11;
                end
                retire = is_j | is_jal | is_jr;
            end
            S_EX: begin
                alu_op = dec_alu;
                if (is_imm || is_lw || is_sw) begin
                    rt_imm_s = 1'b1;
                    imm_s    = dec_imm_s;
                end
                if (is_beq || is_bne) begin
                    pc_write = (is_beq & zf) | (is_bne & ~zf);
                    pc_src   = 2'b01;
                    retire   = 1'b1;
                end
            end
            S_MEM: begin
                mem_read  = is_lw;
                mem_write = is_sw;
                retire    = is_sw & mem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                if (is_imm) w_r_s = 2'b01;
                if (is_lw) begin
                    w_r_s      = 2'b01;
                    w_r_data_s = 2'b01;
                end
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IF;
            wd_cnt      <= '0;
            instr_cnt_q <= '0;
        end else begin
            if ((state_q == S_IF || state_q == S_MEM) && !mem_ready) wd_cnt <= wd_cnt + 1'b1;
            else wd_cnt <= '0;
            if (retire) instr_cnt_q <= instr_cnt_q + 1'b1;
            case (state_q)
                S_IF: begin
                    if (mem_ready) state_q <= S_ID;
                    else if (wd_expire) state_q <= S_ERR;
                end
                S_ID: begin
                    if (!legal) state_q <= S_ERR;
                    else if (is_j || is_jal || is_jr) state_q <= ret_next;
                    else state_q <= S_EX;
                end
                S_EX: begin
                    if (is_beq || is_bne) state_q <= ret_next;
                    else if (is_lw || is_sw) state_q <= S_MEM;
                    else state_q <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) state_q <= is_sw ? ret_next : S_WB;
                    else if (wd_expire) state_q <= S_ERR;
                end
                S_WB:   state_q <= ret_next;
                S_HALT: if (!halt_req) state_q <= S_IF;
                S_ERR:  state_q <= S_ERR;
                default: state_q <= S_ERR;
            endcase
        end
    end

    assign state     = state_q;
    assign err       = (state_q == S_ERR);
    assign halted    = (state_q == S_HALT);
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: a transaction-level model expands each instruction into
// per-cycle expected outputs; a monitor pops and compares them on the falling edge.
module tb_multicycle_ctrl;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 4;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zf;
    logic             mem_ready;
    logic             halt_req;
    logic [2:0]       state;
    logic             mem_read, mem_write, ir_write, pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic [1:0]       w_r_s, w_r_data_s;
    logic             rt_imm_s, imm_s;
    logic [2:0]       alu_op;
    logic             err, halted;
    logic [CNT_W-1:0] instr_cnt;

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zf(zf),
        .mem_ready(mem_ready), .halt_req(halt_req), .state(state),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .w_r_s(w_r_s), .w_r_data_s(w_r_data_s), .rt_imm_s(rt_imm_s),
        .imm_s(imm_s), .alu_op(alu_op), .err(err), .halted(halted),
        .instr_cnt(instr_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [2:0]       state;
        logic             mem_read, mem_write, ir_write, pc_write;
        logic [1:0]       pc_src;
        logic             reg_write;
        logic [1:0]       w_r_s, w_r_data_s;
        logic             rt_imm_s, imm_s;
        logic [2:0]       alu_op;
        logic             err, halted;
        logic [CNT_W-1:0] instr_cnt;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0]    exp_q[$];
    string            tag_q[$];
    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    typedef enum int {C_ILL, C_R, C_JR, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL} cls_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  a;
            logic [EW-1:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {state, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write,
                 w_r_s, w_r_data_s, rt_imm_s, imm_s, alu_op, err, halted, instr_cnt};
            chk(t, 64'(a), 64'(e));
        end
    end

    // ---------------- reference model ----------------
    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn,
                                      output logic [2:0] alu, output logic ims);
        alu = 3'b000;
        ims = 1'b0;
        case (op)
            6'b000000:
                case (fn)
                    6'b100000: begin alu = 3'b010; return C_R; end
                    6'b100010: begin alu = 3'b110; return C_R; end
                    6'b100100: begin alu = 3'b000; return C_R; end
                    6'b100101: begin alu = 3'b001; return C_R; end
                    6'b100110: begin alu = 3'b011; return C_R; end
                    6'b100111: begin alu = 3'b100; return C_R; end
                    6'b101010: begin alu = 3'b111; return C_R; end
                    6'b000010: begin alu = 3'b101; return C_R; end
                    6'b001000: return C_JR;
                    default:   return C_ILL;
                endcase
            6'b001000: begin alu = 3'b010; ims = 1'b1; return C_IMM; end
            6'b001100: begin alu = 3'b000; ims = 1'b0; return C_IMM; end
            6'b001110: begin alu = 3'b011; ims = 1'b0; return C_IMM; end
            6'b001011: begin alu = 3'b111; ims = 1'b1; return C_IMM; end
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000101: return C_BNE;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic exp_t blank(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.state     = st;
        e.err       = (st == 3'd7);
        e.halted    = (st == 3'd5);
        e.instr_cnt = exp_cnt;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic mr, input logic z, input logic hr, input exp_t e, input string tag);
        mem_ready = mr;
        zf        = z;
        halt_req  = hr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        zf        = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_mem_read", 64'(mem_read), 64'(1));
        chk("rst_strobes", 64'({mem_write, ir_write, pc_write, reg_write, err, halted}), 64'(0));
        chk("rst_instr_cnt", 64'(instr_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic after_retire(input logic hr, input int halt_hold);
        exp_cnt = exp_cnt + 1'b1;
        if (hr) begin
            for (int i = 0; i < halt_hold; i++) step(1'($urandom), 1'($urandom), 1'b1, blank(3'd5), "halt_hold");
            step(1'($urandom), 1'($urandom), 1'b0, blank(3'd5), "halt_release");
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int if_wait,
                             input int mem_wait, input logic z, input logic hr,
                             input int halt_hold, input bit abort_mem, output bit trapped);
        cls_t       c;
        logic [2:0] alu;
        logic       ims;
        exp_t       e;
        trapped = 1'b0;
        c = classify(op, fn, alu, ims);
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        for (int i = 0; i < if_wait; i++) begin
            e = blank(3'd0); e.mem_read = 1'b1;
            step(1'b0, 1'($urandom), hr, e, "if_wait");
        end
        e = blank(3'd0); e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(1'b1, 1'($urandom), hr, e, "if_done");
        opcode = op;
        funct  = fn;

        e = blank(3'd1);
        case (c)
            C_ILL: begin
                step(1'($urandom), 1'($urandom), hr, e, "id_illegal");
                for (int i = 0; i < 3; i++)
                    step(1'($urandom), 1'($urandom), 1'($urandom), blank(3'd7), "err_hold");
                trapped = 1'b1;
                return;
            end
            C_J, C_JAL, C_JR: begin
                e.pc_write = 1'b1;
                e.pc_src   = (c == C_JR) ? 2'b11 : 2'b10;
                if (c == C_JAL) begin
                    e.reg_write = 1'b1; e.w_r_s = 2'b10; e.w_r_data_s = 2'b10;
                end
                step(1'($urandom), 1'($urandom), hr, e, "id_jump");
                after_retire(hr, halt_hold);
                return;
            end
            default: step(1'($urandom), 1'($urandom), hr, e, "id");
        endcase

        e = blank(3'd2);
        case (c)
            C_R:   e.alu_op = alu;
            C_IMM: begin e.alu_op = alu; e.rt_imm_s = 1'b1; e.imm_s = ims; end
            C_LW, C_SW: begin e.alu_op = 3'b010; e.rt_imm_s = 1'b1; e.imm_s = 1'b1; end
            default: begin
                e.alu_op   = 3'b110;
                e.pc_src   = 2'b01;
                e.pc_write = (c == C_BEQ) ? z : ~z;
                step(1'($urandom), z, hr, e, "ex_branch");
                after_retire(hr, halt_hold);
                return;
            end
        endcase
        step(1'($urandom), 1'($urandom), hr, e, "ex");

        if (c == C_LW || c == C_SW) begin
            e = blank(3'd3);
            e.mem_read  = (c == C_LW);
            e.mem_write = (c == C_SW);
            for (int i = 0; i < mem_wait; i++) begin
                if (abort_mem) begin
                    mem_ready = 1'b0;
                    halt_req  = hr;
                    exp_q.push_back(e);
                    tag_q.push_back("mem_before_abort");
                    @(negedge clk);
                    #1;
                    rst_n = 1'b0;
                    #1;
                    chk("abort_mem_write", 64'(mem_write), 64'(0));
                    chk("abort_mem_read", 64'(mem_read), 64'(1));
                    chk("abort_state", 64'(state), 64'(0));
                    chk("abort_instr_cnt", 64'(instr_cnt), 64'(0));
                    @(posedge clk);
                    #1;
                    rst_n   = 1'b1;
                    exp_cnt = '0;
                    trapped = 1'b1;
                    return;
                end
                step(1'b0, 1'($urandom), hr, e, "mem_wait");
            end
            step(1'b1, 1'($urandom), hr, e, "mem_done");
            if (c == C_SW) begin
                after_retire(hr, halt_hold);
                return;
            end
        end

        e = blank(3'd4);
        e.reg_write = 1'b1;
        if (c == C_IMM) e.w_r_s = 2'b01;
        if (c == C_LW) begin e.w_r_s = 2'b01; e.w_r_data_s = 2'b01; end
        step(1'($urandom), 1'($urandom), hr, e, "wb");
        after_retire(hr, halt_hold);
    endtask

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case ($urandom_range(0, 19))
            0:  begin op = 6'b000000; fn = 6'b100000; end
            1:  begin op = 6'b000000; fn = 6'b100010; end
            2:  begin op = 6'b000000; fn = 6'b100100; end
            3:  begin op = 6'b000000; fn = 6'b100101; end
            4:  begin op = 6'b000000; fn = 6'b100110; end
            5:  begin op = 6'b000000; fn = 6'b100111; end
            6:  begin op = 6'b000000; fn = 6'b101010; end
            7:  begin op = 6'b000000; fn = 6'b000010; end
            8:  begin op = 6'b000000; fn = 6'b001000; end
            9:  op = 6'b001000;
            10: op = 6'b001100;
            11: op = 6'b001110;
            12: op = 6'b001011;
            13: op = 6'b100011;
            14: op = 6'b101011;
            15: op = 6'b000100;
            16: op = 6'b000101;
            17: op = 6'b000010;
            18: op = 6'b000011;
            default: op = 6'($urandom);
        endcase
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit         tr;
        logic [5:0] op, fn;
        exp_t       e;
        rst_n = 1'b0; opcode = '0; funct = '0; zf = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
        do_reset();

        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0, 0, 1'b0, tr);  // add
        run_instr(6'b100011, 6'b000000, 0, 3, 1'b0, 1'b0, 0, 1'b0, tr);  // lw, 3 waits
        run_instr(6'b000100, 6'b000000, 0, 0, 1'b1, 1'b0, 0, 1'b0, tr);  // beq taken
        run_instr(6'b000100, 6'b000000, 0, 0, 1'b0, 1'b0, 0, 1'b0, tr);  // beq not taken
        run_instr(6'b000101, 6'b000000, 0, 0, 1'b1, 1'b0, 0, 1'b0, tr);  // bne not taken
        run_instr(6'b000101, 6'b000000, 0, 0, 1'b0, 1'b0, 0, 1'b0, tr);  // bne taken
        run_instr(6'b000011, 6'b000000, 0, 0, 1'b0, 1'b0, 0, 1'b0, tr);  // jal

        // IF watchdog expiry: four cycles without mem_ready, then sticky ERR
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            e = blank(3'd0); e.mem_read = 1'b1;
            step(1'b0, 1'b0, 1'b0, e, "wd_if_wait");
        end
        for (int i = 0; i < 4; i++) step(1'($urandom), 1'($urandom), 1'($urandom), blank(3'd7), "wd_err");
        do_reset();

        run_instr(6'b000000, 6'b100000, MEM_TIMEOUT - 1, 0, 1'b0, 1'b0, 0, 1'b0, tr);  // ready on last cycle
        run_instr(6'b111111, 6'b000000, 0, 0, 1'b0, 1'b0, 0, 1'b0, tr);  // illegal opcode
        do_reset();
        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, 1'b1, 2, 1'b0, tr);  // halt after add
        run_instr(6'b101011, 6'b000000, 0, 2, 1'b0, 1'b0, 0, 1'b1, tr);  // reset inside sw MEM

        for (int n = 0; n < 200; n++) begin
            pick(op, fn);
            run_instr(op, fn, $urandom_range(0, MEM_TIMEOUT - 1), $urandom_range(0, MEM_TIMEOUT - 1),
                      1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 1'b0, tr);
            if (tr) do_reset();
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
